// File: rtl/disp_pkg.sv
// ----------------------------------------------------------------------------
// disp_pkg : shared digit-image constants and scheduler state encoding
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package disp_pkg;

  localparam int DIGITS = 8;
  localparam int DIG_W  = 5;
  localparam int IMG_W  = DIGITS * DIG_W;

  // Must stay identical to the seven-segment decoder's blank code.
  localparam logic [DIG_W-1:0] DIG_BLANK = 5'h1F;

  localparam logic [1:0] MODE_BANNER = 2'd0;
  localparam logic [1:0] MODE_TXN    = 2'd1;
  localparam logic [1:0] MODE_ALERT  = 2'd2;

  typedef enum logic [1:0] {
    ST_BANNER = 2'd0,
    ST_TXN    = 2'd1,
    ST_ALERT  = 2'd2
  } sched_state_e;

  function automatic logic [IMG_W-1:0] blank_img();
    return {DIGITS{DIG_BLANK}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/display_tick.sv
// ----------------------------------------------------------------------------
// display_tick : divides clk100MHZ down to a one-cycle tick every TICK_DIV clocks
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module display_tick #(
  parameter int TICK_DIV = 10000000
) (
  input  logic clk100MHZ,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk100MHZ) begin
    if (reset || !en) cnt_q <= '0;
    else              cnt_q <= cnt_d;
  end

  assign tick = en && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/display_scheduler.sv
// ----------------------------------------------------------------------------
// display_scheduler : picks alert / transaction / banner image for the display
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module display_scheduler
  import disp_pkg::*;
#(
  parameter int TICK_DIV     = 10000000,
  parameter int BLINK_TICKS  = 5,
  parameter int SCROLL_TICKS = 3
) (
  input  logic             clk100MHZ,
  input  logic             reset,
  input  logic             power,
  input  logic             base_valid,
  input  logic [IMG_W-1:0] base_dig,
  input  logic [7:0]       blink_mask,
  input  logic             banner_en,
  input  logic [IMG_W-1:0] banner_dig,
  input  logic             alert_req,
  input  logic [IMG_W-1:0] alert_dig,
  input  logic [3:0]       alert_ticks,
  input  logic             alert_clear,
  output logic             alert_ack,
  output logic             alert_busy,
  output logic [1:0]       mode,
  output logic             disp_on,
  output logic [IMG_W-1:0] dig_out
);

  localparam int BW = (BLINK_TICKS  > 1) ? $clog2(BLINK_TICKS)  : 1;
  localparam int SW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;

  sched_state_e     state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic [IMG_W-1:0] alert_img_q, alert_img_d;
  logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
  logic             blink_on_q, blink_on_d;
  logic [SW-1:0]    scroll_cnt_q, scroll_cnt_d;
  logic [2:0]       offset_q, offset_d;
  logic [IMG_W-1:0] dig_q, dig_d;
  logic [1:0]       mode_q, mode_d;
  logic             disp_on_q;
  logic             accept;
  logic             tick;

  display_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk100MHZ (clk100MHZ),
    .reset     (reset),
    .en        (power),
    .tick      (tick)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    alert_img_d = alert_img_q;
    accept      = 1'b0;
    if (state_q == ST_ALERT) begin
      if (alert_clear) begin
        state_d = base_valid ? ST_TXN : ST_BANNER;
      end else if (tick) begin
        hold_d = hold_q - 4'd1;
        if (hold_q == 4'd1) state_d = base_valid ? ST_TXN : ST_BANNER;
      end
    end else if (alert_req && !alert_clear) begin
      state_d     = ST_ALERT;
      accept      = 1'b1;
      alert_img_d = alert_dig;
      hold_d      = (alert_ticks == 4'd0) ? 4'd1 : alert_ticks;
    end else begin
      state_d = base_valid ? ST_TXN : ST_BANNER;
    end
  end

  // Blink phase runs in every state; scroll only advances while the banner shows.
  always_comb begin
    blink_cnt_d  = blink_cnt_q;
    blink_on_d   = blink_on_q;
    scroll_cnt_d = scroll_cnt_q;
    offset_d     = offset_q;
    if (tick) begin
      if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = !blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
    if (state_d == ST_BANNER && state_q != ST_BANNER) begin
      scroll_cnt_d = '0;
      offset_d     = 3'd0;
    end else if (state_q == ST_BANNER && tick) begin
      if (scroll_cnt_q == SW'(SCROLL_TICKS - 1)) begin
        scroll_cnt_d = '0;
        offset_d     = offset_q + 3'd1;
      end else begin
        scroll_cnt_d = scroll_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    dig_d  = blank_img();
    mode_d = MODE_BANNER;
    case (state_q)
      ST_ALERT: begin
        dig_d  = alert_img_q;
        mode_d = MODE_ALERT;
      end
      ST_TXN: begin
        mode_d = MODE_TXN;
        for (int i = 0; i < DIGITS; i++) begin
          dig_d[i*DIG_W +: DIG_W] = (blink_mask[i] && !blink_on_q) ?
                                    DIG_BLANK : base_dig[i*DIG_W +: DIG_W];
        end
      end
      default: begin
        if (banner_en) begin
          // Left rotation by offset digits: output digit i takes source digit i-offset.
          for (int i = 0; i < DIGITS; i++) begin
            logic [2:0] src;
            src = 3'(i) - offset_q;
            dig_d[i*DIG_W +: DIG_W] = banner_dig[src*DIG_W +: DIG_W];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk100MHZ) begin
    if (reset || !power) begin
      state_q      <= ST_BANNER;
      hold_q       <= 4'd0;
      alert_img_q  <= blank_img();
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
      scroll_cnt_q <= '0;
      offset_q     <= 3'd0;
      dig_q        <= blank_img();
      mode_q       <= MODE_BANNER;
      disp_on_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      alert_img_q  <= alert_img_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      scroll_cnt_q <= scroll_cnt_d;
      offset_q     <= offset_d;
      dig_q        <= dig_d;
      mode_q       <= mode_d;
      disp_on_q    <= power;
    end
  end

  assign alert_ack  = accept && power && !reset;
  assign alert_busy = (state_q == ST_ALERT);
  assign mode       = mode_q;
  assign disp_on    = disp_on_q;
  assign dig_out    = dig_q;

endmodule

`default_nettype wire

// File: tb/tb_display_scheduler.sv
// ----------------------------------------------------------------------------
// tb_display_scheduler : directed + random stimulus against a behavioural model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_display_scheduler;
  import disp_pkg::*;

  localparam int TD = 4;
  localparam int BT = 2;
  localparam int ST = 1;

  logic        clk = 1'b0;
  logic        reset, power, base_valid, banner_en, alert_req, alert_clear;
  logic [39:0] base_dig, banner_dig, alert_dig;
  logic [7:0]  blink_mask;
  logic [3:0]  alert_ticks;
  logic        alert_ack, alert_busy, disp_on;
  logic [1:0]  mode;
  logic [39:0] dig_out;

  display_scheduler #(.TICK_DIV(TD), .BLINK_TICKS(BT), .SCROLL_TICKS(ST)) dut (
    .clk100MHZ   (clk),
    .reset       (reset),
    .power       (power),
    .base_valid  (base_valid),
    .base_dig    (base_dig),
    .blink_mask  (blink_mask),
    .banner_en   (banner_en),
    .banner_dig  (banner_dig),
    .alert_req   (alert_req),
    .alert_dig   (alert_dig),
    .alert_ticks (alert_ticks),
    .alert_clear (alert_clear),
    .alert_ack   (alert_ack),
    .alert_busy  (alert_busy),
    .mode        (mode),
    .disp_on     (disp_on),
    .dig_out     (dig_out)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: 0 = banner, 1 = transaction, 2 = alert
  int          m_state = 0;
  int          m_div = 0, m_hold = 0, m_bcnt = 0, m_scnt = 0, m_off = 0;
  bit          m_blink_on = 1'b1;
  logic [39:0] m_img = '0;
  logic [39:0] e_dig = 40'hFF_FFFF_FFFF;
  logic [1:0]  e_mode = 2'd0;
  logic        e_disp = 1'b0;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] rotl_img(input logic [39:0] b, input int off);
    logic [79:0] d;
    d = {b, b} << (DIG_W * off);
    return d[79:40];
  endfunction

  function automatic logic [39:0] blink_img(input logic [39:0] b, input logic [7:0] m, input bit on);
    logic [39:0] r;
    r = b;
    if (!on)
      for (int i = 0; i < 8; i++)
        if (m[i]) r[i*5 +: 5] = 5'h1F;
    return r;
  endfunction

  function automatic logic [39:0] rnd40();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[39:0];
  endfunction

  // Advances the model by one clock edge using the input values present at that edge.
  task automatic model_edge();
    bit tick;
    int nxt;
    if (reset || !power) begin
      m_state = 0; m_div = 0; m_hold = 0; m_bcnt = 0; m_scnt = 0; m_off = 0;
      m_blink_on = 1'b1;
      e_dig = 40'hFF_FFFF_FFFF; e_mode = 2'd0; e_disp = 1'b0;
    end else begin
      tick  = (m_div == TD - 1);
      m_div = (m_div + 1) % TD;
      e_disp = 1'b1;
      e_mode = 2'(m_state);
      if (m_state == 2)      e_dig = m_img;
      else if (m_state == 1) e_dig = blink_img(base_dig, blink_mask, m_blink_on);
      else                   e_dig = banner_en ? rotl_img(banner_dig, m_off) : 40'hFF_FFFF_FFFF;
      nxt = m_state;
      if (m_state == 2) begin
        if (alert_clear) nxt = base_valid ? 1 : 0;
        else if (tick) begin
          m_hold--;
          if (m_hold == 0) nxt = base_valid ? 1 : 0;
        end
      end else if (alert_req && !alert_clear) begin
        nxt    = 2;
        m_img  = alert_dig;
        m_hold = (alert_ticks == 0) ? 1 : int'(alert_ticks);
      end else begin
        nxt = base_valid ? 1 : 0;
      end
      if (tick) begin
        m_bcnt++;
        if (m_bcnt == BT) begin m_bcnt = 0; m_blink_on = !m_blink_on; end
      end
      if (nxt == 0 && m_state != 0) begin
        m_off = 0; m_scnt = 0;
      end else if (m_state == 0 && tick) begin
        m_scnt++;
        if (m_scnt == ST) begin m_scnt = 0; m_off = (m_off + 1) % 8; end
      end
      m_state = nxt;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check("alert_ack", 40'(alert_ack),
          40'(power && !reset && m_state != 2 && alert_req && !alert_clear));
    check("alert_busy", 40'(alert_busy), 40'(m_state == 2));
    @(posedge clk);
    model_edge();
    #1;
    check("dig_out", dig_out, e_dig);
    check("mode", 40'(mode), 40'(e_mode));
    check("disp_on", 40'(disp_on), 40'(e_disp));
  endtask

  initial begin
    reset = 1'b1; power = 1'b0; base_valid = 1'b0; banner_en = 1'b0;
    alert_req = 1'b0; alert_clear = 1'b0; alert_ticks = 4'd0;
    base_dig = '0; banner_dig = '0; alert_dig = '0; blink_mask = '0;
    @(posedge clk); model_edge(); #1;
    step(); step();
    check("reset_dig", dig_out, 40'hFF_FFFF_FFFF);
    check("reset_mode", 40'(mode), 40'd0);
    check("reset_busy", 40'(alert_busy), 40'd0);

    // Banner scroll: digits 0..7 hold values 0..7
    reset = 1'b0; power = 1'b1; banner_en = 1'b1;
    for (int i = 0; i < 8; i++) banner_dig[i*5 +: 5] = 5'(i);
    repeat (40) step();
    base_valid = 1'b1; step(); base_valid = 1'b0;
    repeat (20) step();
    banner_en = 1'b0; repeat (4) step(); banner_en = 1'b1;

    // Blink on digit 0 only, then random masks
    base_valid = 1'b1; base_dig = {8{5'd9}}; blink_mask = 8'h01;
    repeat (40) step();
    blink_mask = 8'($urandom); base_dig = rnd40();
    repeat (20) step();

    // Alert hold of 3 ticks, then 0 ticks (treated as 1)
    alert_ticks = 4'd3; alert_dig = rnd40(); alert_req = 1'b1; step(); alert_req = 1'b0;
    repeat (20) step();
    alert_ticks = 4'd0; alert_dig = rnd40(); alert_req = 1'b1; step(); alert_req = 1'b0;
    repeat (10) step();

    // Request held through an alert: re-accepted after exit with the new image
    alert_ticks = 4'd2; alert_req = 1'b1;
    repeat (40) begin alert_dig = rnd40(); step(); end
    alert_req = 1'b0; repeat (12) step();

    // Clear mid-hold
    alert_ticks = 4'd5; alert_dig = rnd40(); alert_req = 1'b1; step(); alert_req = 1'b0;
    repeat (6) step();
    alert_clear = 1'b1; step(); alert_clear = 1'b0;
    repeat (5) step();

    // Request and clear together outside and inside an alert
    alert_req = 1'b1; alert_clear = 1'b1; step(); step();
    alert_clear = 1'b0; step();
    alert_clear = 1'b1; step(); alert_clear = 1'b0;
    repeat (3) step();
    alert_req = 1'b0; repeat (20) step();

    // Power drop mid-transaction view
    power = 1'b0; step(); step();
    check("pwr_dig", dig_out, 40'hFF_FFFF_FFFF);
    check("pwr_mode", 40'(mode), 40'd0);
    check("pwr_disp", 40'(disp_on), 40'd0);
    alert_req = 1'b1; step(); alert_req = 1'b0;
    power = 1'b1; repeat (10) step();

    // Random traffic
    repeat (500) begin
      reset       = ($urandom_range(0, 149) == 0);
      power       = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 9) == 0) base_valid = ~base_valid;
      if ($urandom_range(0, 19) == 0) banner_en = ~banner_en;
      if ($urandom_range(0, 29) == 0) begin blink_mask = 8'($urandom); base_dig = rnd40(); end
      if ($urandom_range(0, 49) == 0) banner_dig = rnd40();
      alert_req   = ($urandom_range(0, 7) == 0) ? ~alert_req : alert_req;
      alert_clear = ($urandom_range(0, 24) == 0);
      alert_ticks = 4'($urandom_range(0, 6));
      alert_dig   = rnd40();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
